// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: FSM states, opcode constants, field offsets.
package decode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] OPC_LW    = 5'b01000;
    localparam logic [4:0] OPC_SW    = 5'b00111;

    // Field offsets inside the header (opcode, rd, rs, rt), counted from the
    // header LSB, which is the LSB of rt.
    function automatic int rt_lsb(input int reg_aw);
        return 0;
    endfunction

    function automatic int rs_lsb(input int reg_aw);
        return reg_aw;
    endfunction

    function automatic int rd_lsb(input int reg_aw);
        return 2 * reg_aw;
    endfunction

    function automatic int opc_lsb(input int reg_aw);
        return 3 * reg_aw;
    endfunction

endpackage

// File: rtl/field_extract.sv
// Pulls register specifiers out of an instruction header and picks the
// two source registers (rt is a source only for R-type).
module field_extract
    import decode_pkg::*;
#(
    parameter int OPC_W  = 5,
    parameter int REG_AW = 5,
    parameter int HDR_W  = OPC_W + 3 * REG_AW
) (
    input  logic [HDR_W-1:0]  hdr,
    output logic [REG_AW-1:0] src_a,
    output logic [REG_AW-1:0] src_b,
    output logic              is_rtype
);

    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;

    assign opcode = hdr[opc_lsb(REG_AW) +: OPC_W];
    assign rd     = hdr[rd_lsb(REG_AW)  +: REG_AW];
    assign rs     = hdr[rs_lsb(REG_AW)  +: REG_AW];
    assign rt     = hdr[rt_lsb(REG_AW)  +: REG_AW];

    // Source selection: R-type reads rs/rt, everything else reads rs/rd.
    always_comb begin
        is_rtype = (opcode == '0);
        src_a    = rs;
        src_b    = is_rtype ? rt : rd;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one-entry holding register with valid/ready
// handshakes, load-use hazard stall, flush, and a saturating stall counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INSN_W = 32,
    parameter int OPC_W  = 5,
    parameter int REG_AW = 5,
    parameter int PC_W   = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSN_W-1:0] in_ir,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] out_ir,
    output logic [PC_W-1:0]   out_pc,
    output logic [REG_AW-1:0] readRegA,
    output logic [REG_AW-1:0] readRegB,
    output logic              rtOp,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int HDR_W = OPC_W + 3 * REG_AW;

    state_t             state_reg;
    state_t             state_next;
    logic [INSN_W-1:0]  ir_reg;
    logic [PC_W-1:0]    pc_reg;
    logic [REG_AW-1:0]  src_a_reg;
    logic [REG_AW-1:0]  src_b_reg;
    logic               rtype_reg;
    logic [CNT_W-1:0]   stall_cnt_reg;

    logic [REG_AW-1:0]  src_a;
    logic [REG_AW-1:0]  src_b;
    logic               is_rtype;
    logic               hazard;
    logic               accept;

    field_extract #(
        .OPC_W  (OPC_W),
        .REG_AW (REG_AW),
        .HDR_W  (HDR_W)
    ) u_field_extract (
        .hdr      (in_ir[INSN_W-1 -: HDR_W]),
        .src_a    (src_a),
        .src_b    (src_b),
        .is_rtype (is_rtype)
    );

    assign out_valid   = (state_reg == ST_HOLD);
    assign out_ir      = ir_reg;
    assign out_pc      = pc_reg;
    assign readRegA    = src_a_reg;
    assign readRegB    = src_b_reg;
    assign rtOp        = rtype_reg;
    assign stall_count = stall_cnt_reg;

    // Load-use hazard detection and the upstream ready/accept decision.
    always_comb begin
        hazard   = in_valid && ex_load && (ex_rd != '0) &&
                   ((ex_rd == src_a) || (ex_rd == src_b));
        in_ready = reset_n && !flush && (!out_valid || out_ready) && !hazard;
        accept   = in_valid && in_ready;
    end

    // Next-state logic: flush wins, then accept, then hazard bubble.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_IDLE;
        end else if (accept) begin
            state_next = ST_HOLD;
        end else if (hazard && (out_ready || !out_valid)) begin
            state_next = ST_STALL;
        end else begin
            case (state_reg)
                ST_HOLD:  state_next = out_ready ? ST_IDLE : ST_HOLD;
                ST_STALL: state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Holding register: loads only on an accepted instruction.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ir_reg    <= '0;
            pc_reg    <= '0;
            src_a_reg <= '0;
            src_b_reg <= '0;
            rtype_reg <= 1'b0;
        end else if (accept) begin
            ir_reg    <= in_ir;
            pc_reg    <= in_pc;
            src_a_reg <= src_a;
            src_b_reg <= src_b;
            rtype_reg <= is_rtype;
        end
    end

    // Saturating count of hazard cycles not masked by a flush.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cnt_reg <= '0;
        end else if (hazard && !flush && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed checks of decode_stage against a transaction-level
// model of the stage (held entry + counter).
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ir;
    logic [11:0] in_pc;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [11:0] out_pc;
    logic [4:0]  readRegA;
    logic [4:0]  readRegB;
    logic        rtOp;
    logic [15:0] stall_count;

    decode_stage dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ir       (in_ir),
        .in_pc       (in_pc),
        .ex_load     (ex_load),
        .ex_rd       (ex_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ir      (out_ir),
        .out_pc      (out_pc),
        .readRegA    (readRegA),
        .readRegB    (readRegB),
        .rtOp        (rtOp),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: what the stage is holding and how many stalls it has seen.
    logic        m_valid;
    logic [31:0] m_ir;
    logic [11:0] m_pc;
    int          m_ra;
    int          m_rb;
    int          m_rt;
    int          m_cnt;
    logic        last_in_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural view of an instruction: source registers and R-type flag.
    function automatic void ref_decode(input logic [31:0] ir, output int a, output int b, output int r);
        int opc, rd, rs, rt;
        opc = int'(ir >> 27) & 31;
        rd  = int'(ir >> 22) & 31;
        rs  = int'(ir >> 17) & 31;
        rt  = int'(ir >> 12) & 31;
        a = rs;
        b = (opc == 0) ? rt : rd;
        r = (opc == 0) ? 1 : 0;
    endfunction

    task automatic step(input logic rst_i, input logic fl_i, input logic iv_i,
                        input logic [31:0] ir_i, input logic [11:0] pc_i,
                        input logic ld_i, input logic [4:0] exrd_i, input logic ordy_i);
        int a, b, r;
        bit hz, rdy, acc;
        @(negedge clock);
        reset_n = rst_i; flush = fl_i; in_valid = iv_i; in_ir = ir_i; in_pc = pc_i;
        ex_load = ld_i; ex_rd = exrd_i; out_ready = ordy_i;
        #1;
        ref_decode(ir_i, a, b, r);
        hz  = iv_i && ld_i && (exrd_i != 0) && ((int'(exrd_i) == a) || (int'(exrd_i) == b));
        rdy = rst_i && !fl_i && (!m_valid || ordy_i) && !hz;
        acc = iv_i && rdy;
        last_in_ready = in_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        if (!rst_i) begin
            m_valid = 0; m_ir = 0; m_pc = 0; m_ra = 0; m_rb = 0; m_rt = 0; m_cnt = 0;
        end else begin
            if (hz && !fl_i) m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
            if (fl_i) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_ir = ir_i; m_pc = pc_i; m_ra = a; m_rb = b; m_rt = r;
            end else if (ordy_i) m_valid = 0;
        end
        @(posedge clock);
        #1;
        chk("out_valid",   {31'b0, out_valid}, {31'b0, m_valid});
        chk("out_ir",      out_ir, m_ir);
        chk("out_pc",      {20'b0, out_pc}, {20'b0, m_pc});
        chk("readRegA",    {27'b0, readRegA}, 32'(m_ra));
        chk("readRegB",    {27'b0, readRegB}, 32'(m_rb));
        chk("rtOp",        {31'b0, rtOp}, 32'(m_rt));
        chk("stall_count", {16'b0, stall_count}, 32'(m_cnt));
    endtask

    initial begin
        logic [4:0]  f_opc, f_rd, f_rs, f_rt;
        logic [11:0] f_lo;
        logic [31:0] r_ir;
        reset_n = 0; flush = 0; in_valid = 0; in_ir = 0; in_pc = 0;
        ex_load = 0; ex_rd = 0; out_ready = 0;
        m_valid = 0; m_ir = 0; m_pc = 0; m_ra = 0; m_rb = 0; m_rt = 0; m_cnt = 0;
        last_in_ready = 0;

        // Reset state, with an instruction offered (must not be taken).
        step(0, 0, 1, 32'h00C22000, 12'h010, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_in_ready", {31'b0, last_in_ready}, 32'd0);
        $display("reset: out_valid=%0b stall_count=%0d", out_valid, stall_count);

        // R-type decode.
        step(1, 0, 1, 32'h00C22000, 12'h100, 0, 0, 1);
        chk("rtype_valid", {31'b0, out_valid}, 32'd1);
        chk("rtype_rA", {27'b0, readRegA}, 32'd1);
        chk("rtype_rB", {27'b0, readRegB}, 32'd2);
        chk("rtype_op", {31'b0, rtOp}, 32'd1);
        $display("rtype: ir=%h rA=%0d rB=%0d rtOp=%0b", out_ir, readRegA, readRegB, rtOp);

        // I-type decode.
        step(1, 0, 1, 32'h290A0007, 12'h104, 0, 0, 1);
        chk("itype_rA", {27'b0, readRegA}, 32'd5);
        chk("itype_rB", {27'b0, readRegB}, 32'd4);
        chk("itype_op", {31'b0, rtOp}, 32'd0);
        $display("itype: ir=%h rA=%0d rB=%0d rtOp=%0b", out_ir, readRegA, readRegB, rtOp);

        // Load-use stall then release.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 32'h00C22000, 12'h108, 1, 5'd1, 1);
        chk("lu_in_ready", {31'b0, last_in_ready}, 32'd0);
        chk("lu_valid", {31'b0, out_valid}, 32'd0);
        chk("lu_count", {16'b0, stall_count}, 32'd1);
        step(1, 0, 1, 32'h00C22000, 12'h108, 0, 5'd1, 1);
        chk("lu_release", {31'b0, last_in_ready}, 32'd1);
        chk("lu_rel_valid", {31'b0, out_valid}, 32'd1);
        $display("load-use: stall_count=%0d out_valid=%0b", stall_count, out_valid);

        // Register 0 never stalls.
        step(1, 0, 1, 32'h00C00000, 12'h10C, 1, 5'd0, 1);
        chk("r0_in_ready", {31'b0, last_in_ready}, 32'd1);
        chk("r0_count", {16'b0, stall_count}, 32'd1);

        // Backpressure for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 32'h290A0007 + 32'(i), 12'h200 + 12'(i), 0, 0, 0);
            chk("bp_in_ready", {31'b0, last_in_ready}, 32'd0);
            chk("bp_ir", out_ir, 32'h00C00000);
            $display("backpressure %0d: out_ir=%h out_valid=%0b", i, out_ir, out_valid);
        end

        // Flush of a held instruction.
        step(1, 1, 1, 32'h290A0007, 12'h300, 0, 0, 0);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, last_in_ready}, 32'd0);
        $display("flush: out_valid=%0b", out_valid);

        // Random traffic with small register numbers so hazards are frequent.
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 3))
                0: f_opc = 5'b00000;
                1: f_opc = 5'b01000;
                2: f_opc = 5'b00111;
                default: f_opc = 5'($urandom_range(0, 31));
            endcase
            f_rd = 5'($urandom_range(0, 3));
            f_rs = 5'($urandom_range(0, 3));
            f_rt = 5'($urandom_range(0, 3));
            f_lo = 12'($urandom);
            r_ir = {f_opc, f_rd, f_rs, f_rt, f_lo};
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 8), r_ir, 12'($urandom),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 7));
            if (n % 100 == 0)
                $display("random %0d: ir=%h out_valid=%0b stalls=%0d", n, r_ir, out_valid, stall_count);
        end

        // Reset mid-stream discards the held instruction.
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 32'h00C22000, 12'hABC, 0, 0, 0);
        step(0, 0, 1, 32'h290A0007, 12'h123, 0, 0, 0);
        chk("mrst_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_ir", out_ir, 32'd0);
        chk("mrst_pc", {20'b0, out_pc}, 32'd0);
        chk("mrst_rA", {27'b0, readRegA}, 32'd0);
        chk("mrst_rB", {27'b0, readRegB}, 32'd0);
        chk("mrst_op", {31'b0, rtOp}, 32'd0);
        chk("mrst_cnt", {16'b0, stall_count}, 32'd0);
        $display("mid reset: out_valid=%0b out_ir=%h stall_count=%0d", out_valid, out_ir, stall_count);

        // Counter saturation: 2^16 + 5 hazard cycles.
        for (int n = 0; n < 65536 + 5; n++)
            step(1, 0, 1, 32'h00C22000, 12'h000, 1, 5'd2, 1);
        chk("sat_count", {16'b0, stall_count}, 32'h0000FFFF);
        $display("saturation: stall_count=%h", stall_count);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
